image_stream_dma: RTL and testbench

- Moves image pixels between an external 8-bit pixel stream and the segmented data memory.
- LOAD mode writes an incoming stream into the Imagen1 segment (word addresses 400-22899).
- UNLOAD mode reads the Imagen2 segment (word addresses 22900-45399) and streams it out.
- Sits beside the CPU on the memory a/wd/we/rd port. Memory access is gated by mem_gnt, which the top level asserts while the CPU is stalled.

---
 rtl/image_stream_dma_if.sv | 32 +++
 rtl/image_stream_dma.sv | 141 ++++++++++++++
 tb/tb_image_stream_dma.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_stream_dma_if.sv
// Signal bundle between the image stream DMA and its system: command, pixel
// streams in both directions, and the shared memory a/wd/we/rd port.
interface image_stream_dma_if;
   logic        start;
   logic        mode;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] a;
   logic [31:0] wd;
   logic        we;
   logic [31:0] rd;

   // DMA side
   modport master (
      input  start, mode, in_valid, in_data, out_ready, mem_gnt, rd,
      output busy, done, in_ready, out_valid, out_data, mem_req, a, wd, we
   );

   // System side: command source, stream endpoints, memory and arbiter
   modport slave (
      output start, mode, in_valid, in_data, out_ready, mem_gnt, rd,
      input  busy, done, in_ready, out_valid, out_data, mem_req, a, wd, we
   );
endinterface

// File: rtl/image_stream_dma.sv
// Frame DMA: LOAD streams pixels into the Imagen1 segment, UNLOAD reads the
// Imagen2 segment back out as a pixel stream, one memory word per pixel.
module image_stream_dma #(
   parameter int unsigned IMG_W       = 150,
   parameter int unsigned IMG_H       = 150,
   parameter int unsigned LOAD_BASE   = 400,
   parameter int unsigned UNLOAD_BASE = 22900
) (
   input  logic                       clk,
   input  logic                       rst_n,
   image_stream_dma_if.master         bus
);

   localparam logic [14:0] LAST_IDX = 15'(IMG_W * IMG_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UL_READ,
      S_UL_CAPT,
      S_UL_SEND,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [14:0] idx_q, idx_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        mem_req_c;
   logic        in_ready_c;
   logic        we_c;
   logic [31:0] a_c;
   logic [31:0] wd_c;

   // Only the low byte of a memory word carries a pixel.
   logic unused_rd_hi;
   assign unused_rd_hi = ^bus.rd[31:8];

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      state_d    = state_q;
      idx_d      = idx_q;
      out_data_d = out_data_q;
      mem_req_c  = 1'b0;
      in_ready_c = 1'b0;
      we_c       = 1'b0;
      a_c        = '0;
      wd_c       = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               idx_d   = '0;
               state_d = bus.mode ? S_UL_READ : S_LOAD;
            end
         end

         S_LOAD: begin
            mem_req_c  = 1'b1;
            in_ready_c = bus.mem_gnt;
            // Write only while the port is granted; the source holds its pixel otherwise.
            if (bus.in_valid && bus.mem_gnt) begin
               we_c = 1'b1;
               a_c  = 32'(LOAD_BASE) + {17'b0, idx_q};
               wd_c = {24'b0, bus.in_data};
               if (idx_q == LAST_IDX) state_d = S_DONE;
               else                   idx_d   = idx_q + 15'd1;
            end
         end

         S_UL_READ: begin
            mem_req_c = 1'b1;
            if (bus.mem_gnt) begin
               a_c     = 32'(UNLOAD_BASE) + {17'b0, idx_q};
               state_d = S_UL_CAPT;
            end
         end

         S_UL_CAPT: begin
            out_data_d = bus.rd[7:0];
            state_d    = S_UL_SEND;
         end

         S_UL_SEND: begin
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 15'd1;
                  state_d = S_UL_READ;
               end
            end
         end

         S_DONE:  state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered copies of the next state.
      out_valid_d = (state_d == S_UL_SEND);
      busy_d      = (state_d == S_LOAD) || (state_d == S_UL_READ) ||
                    (state_d == S_UL_CAPT) || (state_d == S_UL_SEND);
      done_d      = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.in_ready  = in_ready_c;
   assign bus.mem_req   = mem_req_c;
   assign bus.we        = we_c;
   assign bus.a         = a_c;
   assign bus.wd        = wd_c;

endmodule

// File: tb/tb_image_stream_dma.sv
// Scoreboard bench: a full-size DUT runs one continuous LOAD; a small-frame DUT
// covers gated LOAD, UNLOAD with stall, ignored start and mid-frame reset.
module tb_image_stream_dma;

   localparam int unsigned SW = 12;
   localparam int unsigned SH = 10;
   localparam int unsigned SN = SW * SH;
   localparam int unsigned FN = 150 * 150;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   image_stream_dma_if p_if ();
   image_stream_dma_if f_if ();

   image_stream_dma #(
      .IMG_W(SW), .IMG_H(SH), .LOAD_BASE(400), .UNLOAD_BASE(22900)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(p_if)
   );

   image_stream_dma dut_full (
      .clk(clk), .rst_n(rst_n), .bus(f_if)
   );

   int checks = 0;
   int failures = 0;

   logic [63:0] p_wq[$];
   logic [7:0]  p_oq[$];
   logic [63:0] f_wq[$];
   int p_writes = 0, p_done_cnt = 0, p_out_pops = 0;
   int f_writes = 0, f_done_cnt = 0;
   logic [31:0] f_last_a = '0, f_last_wd = '0;
   bit gnt_toggle = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Memory model for the small DUT: registered read data tagged with the address.
   always @(posedge clk) p_if.rd <= 32'hABCD_0000 | p_if.a;

   // Grant driver: constant grant, or toggling every 4 cycles.
   initial begin
      int g = 0;
      p_if.mem_gnt = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (gnt_toggle) begin
            g++;
            if (g % 4 == 0) p_if.mem_gnt = ~p_if.mem_gnt;
         end else begin
            p_if.mem_gnt = 1'b1;
         end
      end
   end

   // Monitor: compares writes, stream output and done against the scoreboard.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (p_if.we) begin
               p_writes++;
               check("p_we_gating", 32'(p_if.in_valid & p_if.mem_gnt), 32'd1);
               if (p_wq.size() == 0) begin
                  fail_now($sformatf("p_unexpected_write a=0x%08h", p_if.a));
               end else begin
                  e = p_wq.pop_front();
                  check("p_write_addr", p_if.a, e[63:32]);
                  check("p_write_data", p_if.wd, e[31:0]);
               end
            end
            if (p_if.out_valid) begin
               if (p_oq.size() == 0) begin
                  fail_now($sformatf("p_unexpected_out data=0x%02h", p_if.out_data));
               end else begin
                  check("p_out_data", 32'(p_if.out_data), 32'(p_oq[0]));
                  if (p_if.out_ready) begin
                     void'(p_oq.pop_front());
                     p_out_pops++;
                  end else begin
                     check("p_stall_mem_req", 32'(p_if.mem_req), 32'd0);
                  end
               end
            end
            if (p_if.done) begin
               p_done_cnt++;
               check("p_busy_at_done", 32'(p_if.busy), 32'd0);
            end
            if (f_if.we) begin
               f_writes++;
               f_last_a  = f_if.a;
               f_last_wd = f_if.wd;
               if (f_wq.size() == 0) begin
                  fail_now($sformatf("f_unexpected_write a=0x%08h", f_if.a));
               end else begin
                  e = f_wq.pop_front();
                  check("f_write_addr", f_if.a, e[63:32]);
                  check("f_write_data", f_if.wd, e[31:0]);
               end
            end
            if (f_if.done) begin
               f_done_cnt++;
               check("f_busy_at_done", 32'(f_if.busy), 32'd0);
            end
         end
      end
   end

   task automatic check_p_quiet(input string tag);
      check({tag, "_busy"},      32'(p_if.busy),      32'd0);
      check({tag, "_done"},      32'(p_if.done),      32'd0);
      check({tag, "_in_ready"},  32'(p_if.in_ready),  32'd0);
      check({tag, "_out_valid"}, 32'(p_if.out_valid), 32'd0);
      check({tag, "_mem_req"},   32'(p_if.mem_req),   32'd0);
      check({tag, "_we"},        32'(p_if.we),        32'd0);
      check({tag, "_a"},         p_if.a,              32'd0);
      check({tag, "_wd"},        p_if.wd,             32'd0);
      check({tag, "_out_data"},  32'(p_if.out_data),  32'd0);
   endtask

   // All tasks below enter and leave aligned to 1 ns after a rising edge.
   task automatic start_cmd(input logic m);
      p_if.start = 1'b1;
      p_if.mode  = m;
      @(posedge clk);
      #1;
      p_if.start = 1'b0;
      check("p_busy_after_start", 32'(p_if.busy), 32'd1);
   endtask

   task automatic wait_p_done(input int budget, input string name);
      int base = p_done_cnt;
      for (int c = 0; c < budget && p_done_cnt == base; c++) begin
         @(posedge clk);
         #1;
      end
      repeat (4) begin @(posedge clk); #1; end
      check(name, 32'(p_done_cnt - base), 32'd1);
   endtask

   // Streams pixels px[7:0]; returns early (in_valid left high) at abort_at.
   task automatic p_load(input int abort_at, input bit gaps, input int spur_at);
      for (int px = 0; px < int'(SN); px++) begin
         bit hs = 1'b0;
         if (px == abort_at) return;
         if (gaps) begin
            int k = int'($urandom_range(2, 0));
            p_if.in_valid = 1'b0;
            repeat (k) begin @(posedge clk); #1; end
         end
         if (px == spur_at) begin
            p_if.start = 1'b1;
            p_if.mode  = 1'b1;
         end
         p_if.in_valid = 1'b1;
         p_if.in_data  = 8'(px);
         p_wq.push_back({32'(400 + px), 32'(px & 255)});
         for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk);
            hs = p_if.in_ready;
            @(posedge clk);
            #1;
            p_if.start = 1'b0;
         end
         if (!hs) begin
            fail_now($sformatf("p_in_ready_timeout px=%0d", px));
            p_if.in_valid = 1'b0;
            return;
         end
      end
      p_if.in_valid = 1'b0;
   endtask

   task automatic p_unload(input bit stall);
      for (int i = 0; i < int'(SN); i++) p_oq.push_back(8'((22900 + i) & 255));
      p_if.out_ready = 1'b1;
      start_cmd(1'b1);
      check("p_ul_valid_c0", 32'(p_if.out_valid), 32'd0);
      @(posedge clk); #1;
      check("p_ul_valid_c1", 32'(p_if.out_valid), 32'd0);
      @(posedge clk); #1;
      check("p_ul_valid_c2", 32'(p_if.out_valid), 32'd1);
      if (stall) begin
         for (int c = 0; c < 200 && p_out_pops < 5; c++) begin @(posedge clk); #1; end
         p_if.out_ready = 1'b0;
         for (int c = 0; c < 20 && !p_if.out_valid; c++) begin @(posedge clk); #1; end
         check("p_stall_valid", 32'(p_if.out_valid), 32'd1);
         repeat (10) begin @(posedge clk); #1; end
         p_if.out_ready = 1'b1;
      end
      wait_p_done(3 * SN + 50, "p_ul_done_once");
      check("p_oq_drained", 32'(p_oq.size()), 32'd0);
   endtask

   initial begin
      int wbase, dbase, fbase;
      bit hs;
      p_if.start = 1'b0; p_if.mode = 1'b0; p_if.in_valid = 1'b0;
      p_if.in_data = '0; p_if.out_ready = 1'b1;
      f_if.start = 1'b0; f_if.mode = 1'b0; f_if.in_valid = 1'b0;
      f_if.in_data = '0; f_if.out_ready = 1'b1; f_if.mem_gnt = 1'b1; f_if.rd = '0;

      repeat (3) @(posedge clk);
      #1;
      check_p_quiet("reset");
      check("reset_f_busy", 32'(f_if.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-size continuous LOAD: 22500 writes, addresses 400..22899.
      fbase = f_done_cnt;
      f_if.start = 1'b1;
      @(posedge clk); #1;
      f_if.start = 1'b0;
      check("f_busy_after_start", 32'(f_if.busy), 32'd1);
      for (int px = 0; px < int'(FN); px++) begin
         f_if.in_valid = 1'b1;
         f_if.in_data  = 8'(px);
         f_wq.push_back({32'(400 + px), 32'(px & 255)});
         hs = 1'b0;
         for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge clk);
            hs = f_if.in_ready;
            @(posedge clk);
            #1;
         end
         if (!hs) begin
            fail_now($sformatf("f_in_ready_timeout px=%0d", px));
            break;
         end
      end
      f_if.in_valid = 1'b0;
      for (int c = 0; c < 20 && f_done_cnt == fbase; c++) begin @(posedge clk); #1; end
      repeat (4) begin @(posedge clk); #1; end
      check("f_done_once", 32'(f_done_cnt - fbase), 32'd1);
      check("f_write_count", 32'(f_writes), 32'(FN));
      check("f_last_a", f_last_a, 32'(400 + FN - 1));
      check("f_last_wd", f_last_wd, 32'((FN - 1) & 255));
      check("f_idle_busy", 32'(f_if.busy), 32'd0);

      // Gated LOAD: grant toggles every 4 cycles, random valid gaps.
      gnt_toggle = 1'b1;
      wbase = p_writes;
      start_cmd(1'b0);
      p_load(-1, 1'b1, -1);
      wait_p_done(50, "p_gated_done_once");
      check("p_gated_writes", 32'(p_writes - wbase), 32'(SN));
      check("p_wq_drained_gated", 32'(p_wq.size()), 32'd0);
      gnt_toggle = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // UNLOAD, free-running sink, then with a 10-cycle stall at pixel 5.
      p_unload(1'b0);
      p_out_pops = 0;
      p_unload(1'b1);

      // Start with mode=1 pulsed during a busy LOAD must be ignored.
      wbase = p_writes;
      start_cmd(1'b0);
      p_load(-1, 1'b0, 30);
      wait_p_done(50, "p_spur_done_once");
      check("p_spur_writes", 32'(p_writes - wbase), 32'(SN));
      check("p_spur_idle", 32'(p_if.busy), 32'd0);

      // Reset at pixel 40 of a LOAD, then a clean LOAD from address 400.
      dbase = p_done_cnt;
      start_cmd(1'b0);
      p_load(40, 1'b0, -1);
      check("p_pre_reset_we", 32'(p_if.we), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_p_quiet("midrst");
      p_if.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      check("p_no_done_after_abort", 32'(p_done_cnt - dbase), 32'd0);
      check("p_wq_empty_after_abort", 32'(p_wq.size()), 32'd0);
      wbase = p_writes;
      start_cmd(1'b0);
      p_load(-1, 1'b0, -1);
      wait_p_done(50, "p_reload_done_once");
      check("p_reload_writes", 32'(p_writes - wbase), 32'(SN));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
